reg_file_8x16: RTL
==================

// Module: reg_file_8x16
// PURPOSE
//  General-purpose register file: the write-back consumer of the 16-bit 4:1 write-back source mux.
//  Stores the mux output into the addressed register on the clock edge and supplies two combinational operand read ports to the ALU path.
//  Includes a sequential debug dump port that streams every register out, one per cycle, for bench/board inspection.
// PARAMETERS
//  DATA_WIDTH  16  width of each register and of all data ports
//  ADDR_WIDTH  3   register address width; NUM_REGS = 2**ADDR_WIDTH (8)
//  ZERO_REG    1   1: R0 reads as 0 and ignores writes; 0: R0 is an ordinary register
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  we         in   1           write enable
//  wr_addr    in   ADDR_WIDTH  write register index
//  wr_data    in   DATA_WIDTH  write data (write-back mux output)
//  rd_addr1   in   ADDR_WIDTH  read port 1 index
//  rd_addr2   in   ADDR_WIDTH  read port 2 index
//  rd_data1   out  DATA_WIDTH  read port 1 data (combinational)
//  rd_data2   out  DATA_WIDTH  read port 2 data (combinational)
//  dbg_req    in   1           start register dump (sampled on clk edge)
//  dbg_busy   out  1           dump in progress
//  dbg_valid  out  1           dbg_addr/dbg_data valid this cycle
//  dbg_addr   out  ADDR_WIDTH  index of register being dumped
//  dbg_data   out  DATA_WIDTH  dumped register value
// BEHAVIOUR
//  Reset (async, immediate): all registers = 0; FSM = IDLE; dbg_busy/dbg_valid = 0; dbg_addr/dbg_data = 0; dump index = 0.
//  Write: rising edge with we=1 -> reg[wr_addr] <= wr_data; suppressed if ZERO_REG=1 and wr_addr=0.
//  Read: combinational, zero latency. Priority:
//   (1) ZERO_REG=1 and rd_addr=0 -> 0.
//   (2) we=1 and wr_addr=rd_addr (write not suppressed) -> wr_data (write-first bypass).
//   (3) otherwise reg[rd_addr]. Both ports are independent; both may read the same register.
//  Dump FSM, states IDLE and DUMP; all dbg_* outputs registered.
//   IDLE: dbg_req=1 at edge E0 -> DUMP, idx=0, dbg_busy=1.
//   DUMP: on each edge: dbg_valid<=1, dbg_addr<=idx, dbg_data<=post-edge value of reg[idx]
//    (includes a write to idx on that same edge; 0 for R0 when ZERO_REG=1); idx<=idx+1.
//   After the edge that emits idx=NUM_REGS-1: state=IDLE, dbg_busy<=0, idx wraps to 0.
//   In IDLE, dbg_valid<=0 and dbg_addr/dbg_data hold their last values.
//   Timing: req at E0 -> addr 0 valid after E1 ... addr 7 valid after E8; dbg_busy high E0..E8; dbg_valid low after E9.
//   dbg_req while busy: ignored (no restart, no queueing).
//   dbg_req held high: next dump starts at the first edge sampled in IDLE (E9).
//  Dump never blocks or delays normal reads/writes.
//  Reset mid-dump: aborts immediately, all outputs return to reset values, registers cleared.
//  No overflow/arith: data stored verbatim; idx arithmetic is modulo NUM_REGS.
// TESTING
//  1. Assert/release reset; sweep rd_addr1/2 over 0..7 -> all reads 0x0000; dbg_busy=0, dbg_valid=0.
//  2. we=1, wr_addr=3, wr_data=0xBEEF, rd_addr1=3 in the same cycle -> rd_data1=0xBEEF before the edge (bypass); after the edge with we=0 -> still 0xBEEF.
//  3. we=1, wr_addr=0, wr_data=0x1234 -> rd_data1 (addr 0)=0x0000 in the same cycle and afterwards.
//  4. Load R1..R7=0x1111*i; pulse dbg_req one cycle ->
//     8 consecutive dbg_valid cycles, addr 0..7, data 0x0000,0x1111..0x7777; dbg_busy high 9 edges; second dbg_req mid-dump ignored.
//  5. During a dump, write R5=0xAAAA on the edge emitting idx 5 -> dbg_data=0xAAAA at addr 5;
//     write R2=0x5555 after idx 2 emitted -> dump shows old R2 value; rd_data reflects 0x5555.
//  6. Assert reset asynchronously (mid-clock) after addr 3 emitted ->
//     dbg_busy/valid/addr/data=0 immediately, all regs 0; next dbg_req dumps addr 0..7 all 0x0000.

Source files
------------

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: general-purpose register file with two combinational read
// ports (write-first bypass), optional hard-wired zero R0, and a sequential
// debug dump port that streams every register out, one per clock.
module reg_file_8x16 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  dbg_req,
    output logic                  dbg_busy,
    output logic                  dbg_valid,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 3;

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_en;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Port 0/1 are the operand reads; port 2 is the dump tap, which sees the
    // same post-edge value a read would, so a same-edge write is captured.
    logic [ADDR_WIDTH-1:0] rd_sel [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_val [NUM_PORTS];

    assign wr_en     = we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign rd_sel[0] = rd_addr1;
    assign rd_sel[1] = rd_addr2;
    assign rd_sel[2] = idx_q;

    // Register array: async clear, write on enabled rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read muxes: zero register, then write-first bypass, then stored value
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_val[p] = regs_q[rd_sel[p]];
            if ((ZERO_REG != 0) && (rd_sel[p] == '0)) begin
                rd_val[p] = '0;
            end else if (wr_en && (wr_addr == rd_sel[p])) begin
                rd_val[p] = wr_data;
            end
        end
    end

    assign rd_data1 = rd_val[0];
    assign rd_data2 = rd_val[1];

    // Dump FSM state and registered debug outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Dump FSM next state: one register emitted per edge while in DUMP
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (dbg_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            DUMP: begin
                valid_d = 1'b1;
                addr_d  = idx_q;
                data_d  = rd_val[2];
                idx_d   = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign dbg_busy  = busy_q;
    assign dbg_valid = valid_q;
    assign dbg_addr  = addr_q;
    assign dbg_data  = data_q;

endmodule
